aggregator: RTL and testbench

- Packs a stream of DATA_WIDTH words from an interface FIFO into FETCH_WIDTH-wide words and writes them into a double buffer.
- Inverse of the deaggregator. Lane 0 holds the first word received, in bits [DATA_WIDTH-1:0].
- Sits between a first-word-fall-through fifo (sender) and a double buffer write port (receiver).
- A flush input emits a zero-padded partial word at frame end.

---
 rtl/aggregator.sv | 91 +++++++++
 tb/tb_aggregator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aggregator.sv
// Packs a stream of narrow FIFO words into FETCH_WIDTH-lane wide words for a
// double-buffer write port; lane 0 carries the first word received.
module aggregator #(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    input  logic                              flush,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq
);

    localparam int LANE_W = $clog2(FETCH_WIDTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(FETCH_WIDTH - 1);

    typedef logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] wide_t;

    logic [LANE_W-1:0] lane_r;
    wide_t             pack_r;
    wide_t             out_r;
    wide_t             full_word;
    logic              out_valid_r;
    logic              flush_pending_r;
    logic              out_slot_free;
    logic              at_last_lane;

    // The output slot counts as free when it is empty or drains this cycle,
    // which lets a word load and the previous one leave on the same edge.
    assign out_slot_free = !out_valid_r || receiver_full_n;
    assign at_last_lane  = (lane_r == LAST_LANE);

    assign receiver_enq  = rst_n && out_valid_r && receiver_full_n;
    assign sender_deq    = rst_n && sender_empty_n && !flush_pending_r &&
                           (!at_last_lane || out_slot_free);
    assign receiver_data = out_r;

    // NOTE: every variable driven in always_comb gets a full default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        full_word                  = pack_r;
        full_word[FETCH_WIDTH-1]   = sender_data;
    end

    // NOTE: sequential state uses non-blocking assignments only; later
    // assignments in this block intentionally override earlier ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_r          <= '0;
            pack_r          <= '0;
            out_r           <= '0;
            out_valid_r     <= 1'b0;
            flush_pending_r <= 1'b0;
        end else begin
            if (receiver_enq) begin
                out_valid_r <= 1'b0;
            end
            if (flush) begin
                flush_pending_r <= 1'b1;
            end

            if (sender_deq) begin
                if (at_last_lane) begin
                    out_r       <= full_word;
                    out_valid_r <= 1'b1;
                    pack_r      <= '0;
                    lane_r      <= '0;
                end else begin
                    pack_r[lane_r] <= sender_data;
                    lane_r         <= lane_r + 1'b1;
                end
            end else if (flush_pending_r) begin
                // Unwritten lanes are already zero, so pack_r is the padded word.
                if (lane_r == '0) begin
                    flush_pending_r <= 1'b0;
                end else if (out_slot_free) begin
                    out_r           <= pack_r;
                    out_valid_r     <= 1'b1;
                    pack_r          <= '0;
                    lane_r          <= '0;
                    flush_pending_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aggregator.sv
// Self-checking bench for aggregator: directed scenarios plus a randomized run,
// all checked every cycle against a queue-based reference model.
module tb_aggregator;

    localparam int DW = 16;
    localparam int FW = 4;
    localparam int WW = DW * FW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] sender_data;
    logic          sender_empty_n;
    logic          sender_deq;
    logic          flush;
    logic [WW-1:0] receiver_data;
    logic          receiver_full_n;
    logic          receiver_enq;

    aggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .flush           (flush),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus source and observation
    logic [DW-1:0] src[$];
    logic [WW-1:0] got[$];
    bit            en_gate;
    int            deq_cnt;

    // Reference model: words collected so far, one output slot, flush request
    logic [DW-1:0] m_part[$];
    bit            m_out_full;
    logic [WW-1:0] m_out_word;
    bit            m_pend;
    int            m_emits;
    int            enq_total;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack_words(input logic [DW-1:0] q[$]);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) w[i*DW +: DW] = q[i];
        return w;
    endfunction

    task automatic model_step();
        bit e_deq, e_enq, slot_free, new_pend;
        if (!rst_n) begin
            check("deq_in_reset", 64'(sender_deq), 64'(0));
            check("enq_in_reset", 64'(receiver_enq), 64'(0));
            m_part.delete();
            m_out_full = 0;
            m_out_word = '0;
            m_pend     = 0;
            return;
        end
        e_enq     = m_out_full && receiver_full_n;
        slot_free = !m_out_full || receiver_full_n;
        e_deq     = sender_empty_n && !m_pend && (m_part.size() != FW - 1 || slot_free);
        check("sender_deq", 64'(sender_deq), 64'(e_deq));
        check("receiver_enq", 64'(receiver_enq), 64'(e_enq));
        if (m_out_full) check("receiver_data", 64'(receiver_data), 64'(m_out_word));
        if (receiver_enq) begin
            got.push_back(receiver_data);
            enq_total++;
        end
        if (sender_deq) deq_cnt++;

        if (e_enq) begin
            m_out_full = 0;
            m_emits++;
        end
        new_pend = m_pend || flush;
        if (e_deq) begin
            m_part.push_back(sender_data);
            if (m_part.size() == FW) begin
                m_out_word = pack_words(m_part);
                m_out_full = 1;
                m_part.delete();
            end
        end else if (m_pend) begin
            if (m_part.size() == 0) begin
                new_pend = 0;
            end else if (slot_free) begin
                m_out_word = pack_words(m_part);
                m_out_full = 1;
                m_part.delete();
                new_pend = 0;
            end
        end
        m_pend = new_pend;
    endtask

    // One clock cycle: present the FIFO head, check at negedge, pop on deq.
    task automatic tick();
        bit deq_seen;
        sender_empty_n = en_gate && (src.size() != 0);
        sender_data    = (src.size() != 0) ? src[0] : DW'($urandom);
        @(negedge clk);
        model_step();
        deq_seen = sender_deq;
        @(posedge clk);
        #1;
        if (deq_seen && src.size() != 0) void'(src.pop_front());
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        receiver_full_n = 1'b1;
        sender_empty_n  = 1'b0;
        sender_data     = '0;
        en_gate         = 1'b1;
        deq_cnt         = 0;
        m_out_full      = 0;
        m_out_word      = '0;
        m_pend          = 0;
        m_emits         = 0;
        enq_total       = 0;

        // Reset with data waiting: nothing may move
        src.push_back(16'hDEAD);
        repeat (2) tick();
        src.delete();
        rst_n = 1'b1;
        tick();
        check("reset_enq", 64'(receiver_enq), 64'(0));
        check("reset_no_output", 64'(got.size()), 64'(0));

        // 1. Sustained stream
        got.delete(); deq_cnt = 0;
        for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
        repeat (8) tick();
        check("t1_deq_8_consecutive", 64'(deq_cnt), 64'(8));
        check("t1_one_word_so_far", 64'(got.size()), 64'(1));
        tick();
        check("t1_two_words", 64'(got.size()), 64'(2));
        check("t1_word0", 64'(got[0]), 64'h0004_0003_0002_0001);
        check("t1_word1", 64'(got[1]), 64'h0008_0007_0006_0005);

        // 2. Backpressure
        got.delete();
        receiver_full_n = 1'b0;
        for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
        repeat (10) tick();
        check("t2_word8_waiting", 64'(src.size()), 64'(1));
        check("t2_held_data", 64'(receiver_data), 64'h0004_0003_0002_0001);
        check("t2_no_enq_yet", 64'(got.size()), 64'(0));
        receiver_full_n = 1'b1;
        tick();
        check("t2_old_enq", 64'(got.size()), 64'(1));
        check("t2_word8_taken", 64'(src.size()), 64'(0));
        tick();
        check("t2_new_enq", 64'(got.size()), 64'(2));
        check("t2_word1", 64'(got[1]), 64'h0008_0007_0006_0005);

        // 3. Flush partial
        got.delete();
        src.push_back(16'hAAAA);
        src.push_back(16'hBBBB);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        check("t3_one_enq", 64'(got.size()), 64'(1));
        check("t3_padded", 64'(got[0]), 64'h0000_0000_BBBB_AAAA);
        for (int i = 0; i < 4; i++) src.push_back(DW'(16'h1111 * (i + 1)));
        repeat (6) tick();
        check("t3_next_full", 64'(got.size()), 64'(2));
        check("t3_next_word", 64'(got[1]), 64'h4444_3333_2222_1111);

        // 4a. Flush with nothing collected
        got.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        check("t4a_no_enq", 64'(got.size()), 64'(0));

        // 4b. Flush in the cycle of the last lane's deq
        for (int i = 0; i < 4; i++) src.push_back(DW'(16'hC000 + i));
        for (int i = 0; i < 4; i++) begin
            flush = (src.size() == 1);
            tick();
        end
        flush = 1'b0;
        repeat (5) tick();
        check("t4b_single_enq", 64'(got.size()), 64'(1));
        check("t4b_word", 64'(got[0]), 64'hC003_C002_C001_C000);

        // 5. Sender bubbles
        got.delete(); deq_cnt = 0;
        for (int i = 0; i < 4; i++) src.push_back(DW'(16'h5A00 + i));
        for (int i = 0; i < 8; i++) begin
            en_gate = i[0];
            tick();
        end
        en_gate = 1'b1;
        repeat (2) tick();
        check("t5_deq_count", 64'(deq_cnt), 64'(4));
        check("t5_one_word", 64'(got.size()), 64'(1));
        check("t5_word", 64'(got[0]), 64'h5A03_5A02_5A01_5A00);

        // 6. Reset mid-word
        got.delete();
        for (int i = 0; i < 3; i++) src.push_back(DW'(16'hE001 + i));
        repeat (3) tick();
        for (int i = 0; i < 4; i++) src.push_back(DW'(16'h0011 + i));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t6_one_word", 64'(got.size()), 64'(1));
        check("t6_word", 64'(got[0]), 64'h0014_0013_0012_0011);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            while (src.size() < 4) src.push_back(DW'($urandom));
            en_gate         = ($urandom_range(0, 3) != 0);
            receiver_full_n = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 19) == 0);
            rst_n           = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; receiver_full_n = 1'b1; en_gate = 1'b0;
        repeat (10) tick();
        check("total_enq_count", 64'(enq_total), 64'(m_emits));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
